// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and bit-timing helpers, so the
// transmit and receive sides derive identical timing from CLK_FREQ/BAUD_RATE.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_t;

   function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int calc_half_bit(input int clk_freq, input int baud_rate);
      return calc_clks_per_bit(clk_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous level input; resets to 1 so an
// idle-high line does not look like activity right after reset.
module uart_rx_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM, LSB-first shift register and a
// one-entry holding register with valid/ready handshake plus error pulses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s low
// ST_START | half-bit wait, confirm start bit is still low
// ST_DATA  | sample 8 data bits at mid-period, LSB first
// ST_STOP  | sample stop bit; high delivers byte, low flags framing error
// ST_BREAK | line held low after bad stop bit; wait for it to go high
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF_BIT     = calc_half_bit(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

   uart_state_t      state, state_nxt;
   logic             rx_s;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             deliver;

   logic cnt_clr, cnt_inc, bit_clr, bit_inc, shift_en, stop_good, stop_bad;

   uart_rx_sync2 u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      bit_clr   = 1'b0;
      bit_inc   = 1'b0;
      shift_en  = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (!rx_s) state_nxt = ST_START;
         end
         ST_START: begin
            if (clk_cnt == CNT_HALF) begin
               cnt_clr = 1'b1;
               bit_clr = 1'b1;
               state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_DATA: begin
            if (clk_cnt == CNT_LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_nxt = ST_STOP;
               else                 bit_inc   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_STOP: begin
            if (clk_cnt == CNT_LAST) begin
               cnt_clr = 1'b1;
               if (rx_s) begin
                  stop_good = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = ST_BREAK;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_BREAK: begin
            cnt_clr = 1'b1;
            if (rx_s) state_nxt = ST_IDLE;
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clk_cnt <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         if (cnt_clr)      clk_cnt <= '0;
         else if (cnt_inc) clk_cnt <= clk_cnt + 1'b1;
         if (bit_clr)      bit_idx <= 3'd0;
         else if (bit_inc) bit_idx <= bit_idx + 3'd1;
         if (shift_en)     shreg   <= {rx_s, shreg[7:1]};
      end
   end

   // Delivery happens the cycle after the stop-bit sample; shreg is untouched
   // until the next frame reaches DATA, so it is still valid here.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         deliver   <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         deliver   <= stop_good;
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: behavioural serial driver,
// negedge monitor collecting accepted bytes and error pulses.
module tb_uart_rx;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_fails  = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int both_cnt = 0;
   logic [7:0] got_q[$];

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ  (1_000_000),
      .BAUD_RATE (100_000)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_clks(CPB);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_bit);
   endtask

   function automatic logic [7:0] got_at(input int idx);
      if (idx < got_q.size()) return got_q[idx];
      return 8'hxx;
   endfunction

   initial begin
      reset_n  = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      wait_clks(3);
      check("rst_rx_data",   32'(rx_data),   32'h00);
      check("rst_rx_valid",  32'(rx_valid),  32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_overrun",   32'(overrun),   32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      reset_n = 1'b1;
      wait_clks(5);

      // 1: single frame
      send_frame(8'hA5, 1'b1);
      wait_clks(20);
      check("t1_count", 32'(got_q.size()), 32'd1);
      check("t1_data",  32'(got_at(0)),    32'hA5);
      check("t1_fe",    32'(fe_cnt),       32'd0);
      check("t1_busy",  32'(busy),         32'h0);

      // 2: back-to-back frames, no idle gap
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      wait_clks(20);
      check("t2_count", 32'(got_q.size()), 32'd4);
      check("t2_data0", 32'(got_at(1)),    32'h00);
      check("t2_data1", 32'(got_at(2)),    32'hFF);
      check("t2_data2", 32'(got_at(3)),    32'h3C);
      check("t2_fe",    32'(fe_cnt),       32'd0);
      check("t2_ov",    32'(ov_cnt),       32'd0);

      // 3: short low glitch
      rx = 1'b0;
      wait_clks(3);
      rx = 1'b1;
      wait_clks(30);
      check("t3_count", 32'(got_q.size()), 32'd4);
      check("t3_fe",    32'(fe_cnt),       32'd0);
      check("t3_busy",  32'(busy),         32'h0);

      // 4: bad stop bit, line held low, then recovery
      send_frame(8'h5A, 1'b0);
      rx = 1'b0;
      wait_clks(40);
      check("t4_fe",         32'(fe_cnt),       32'd1);
      check("t4_count",      32'(got_q.size()), 32'd4);
      check("t4_valid",      32'(rx_valid),     32'h0);
      check("t4_busy_break", 32'(busy),         32'h1);
      rx = 1'b1;
      wait_clks(5);
      check("t4_busy_idle",  32'(busy),         32'h0);
      send_frame(8'h11, 1'b1);
      wait_clks(20);
      check("t4_count2",     32'(got_q.size()), 32'd5);
      check("t4_data",       32'(got_at(4)),    32'h11);
      check("t4_fe2",        32'(fe_cnt),       32'd1);

      // 5: overrun with consumer stalled
      rx_ready = 1'b0;
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      wait_clks(20);
      check("t5_valid",  32'(rx_valid), 32'h1);
      check("t5_data",   32'(rx_data),  32'h12);
      check("t5_ov",     32'(ov_cnt),   32'd1);
      check("t5_fe",     32'(fe_cnt),   32'd1);
      rx_ready = 1'b1;
      wait_clks(1);
      check("t5_valid_drop", 32'(rx_valid),     32'h0);
      check("t5_count",      32'(got_q.size()), 32'd6);
      check("t5_accepted",   32'(got_at(5)),    32'h12);

      // 6: reset during data bit 4
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx = 1'b0;
      wait_clks(5);
      check("t6_busy_pre", 32'(busy), 32'h1);
      reset_n = 1'b0;
      rx      = 1'b1;
      wait_clks(1);
      check("t6_rx_data",   32'(rx_data),   32'h00);
      check("t6_rx_valid",  32'(rx_valid),  32'h0);
      check("t6_frame_err", 32'(frame_err), 32'h0);
      check("t6_overrun",   32'(overrun),   32'h0);
      check("t6_busy",      32'(busy),      32'h0);
      reset_n = 1'b1;
      wait_clks(20);
      send_frame(8'hC3, 1'b1);
      wait_clks(20);
      check("t6_count", 32'(got_q.size()), 32'd7);
      check("t6_data",  32'(got_at(6)),    32'hC3);
      check("t6_fe",    32'(fe_cnt),       32'd1);
      check("t6_ov",    32'(ov_cnt),       32'd1);

      check("flags_exclusive", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
